// File: rtl/fnd_scan_decoder_if.sv
// Display-side lines of the FND scan plus the rebuilt frame seen by the loopback monitor.
// master drives the scan lines and reads the frame; slave is the decoder.
interface fnd_scan_decoder_if;
  logic [3:0]  fnd_com;
  logic [7:0]  fnd_data;
  logic [15:0] o_digits;
  logic [3:0]  o_dots;
  logic [3:0]  o_bad_seg;
  logic        o_frame_valid;
  logic        o_com_err;
  logic        o_stall;

  modport master (
    output fnd_com, fnd_data,
    input  o_digits, o_dots, o_bad_seg, o_frame_valid, o_com_err, o_stall
  );

  modport slave (
    input  fnd_com, fnd_data,
    output o_digits, o_dots, o_bad_seg, o_frame_valid, o_com_err, o_stall
  );
endinterface

// File: rtl/fnd_scan_decoder.sv
// Rebuilds the four digit codes/dots from the multiplexed FND lines; passive monitor, no backpressure.
// Latency: line change -> settle event 2+SETTLE_CYCLES, -> slot +1, -> frame output +1.
module fnd_scan_decoder #(
  parameter int SETTLE_CYCLES  = 16,
  parameter int TIMEOUT_CYCLES = 250_000
) (
  input  logic              clk,
  input  logic              reset,
  fnd_scan_decoder_if.slave bus
);

  localparam int            CW         = $clog2(SETTLE_CYCLES);
  localparam int            TW         = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CW-1:0] CNT_MAX    = CW'(SETTLE_CYCLES - 1);
  localparam logic [TW-1:0] TMO_MAX    = TW'(TIMEOUT_CYCLES);
  localparam logic [11:0]   IDLE_LINES = 12'hFFF;

  typedef enum logic [1:0] {S_IDLE, S_SETTLE, S_HOLD} state_t;

  logic [11:0]   sync1_q, sync2_q, prev_q;
  logic [CW-1:0] cnt_q, cnt_d;
  state_t        state_q;
  logic          evt_q;
  logic          change;

  // Synchronisers reset to the blank/all-off bus so a quiet display is not seen as a change.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync1_q <= IDLE_LINES;
      sync2_q <= IDLE_LINES;
      prev_q  <= IDLE_LINES;
      cnt_q   <= '0;
    end else begin
      sync1_q <= {bus.fnd_com, bus.fnd_data};
      sync2_q <= sync1_q;
      prev_q  <= sync2_q;
      cnt_q   <= cnt_d;
    end
  end

  assign change = (sync2_q != prev_q);

  always_comb begin
    cnt_d = cnt_q;
    if (change) begin
      cnt_d = '0;
    end else if (cnt_q != CNT_MAX) begin
      cnt_d = cnt_q + CW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      evt_q   <= 1'b0;
    end else begin
      evt_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (change) state_q <= S_SETTLE;
        end
        S_SETTLE: begin
          if (change) begin
            state_q <= S_IDLE;
          end else if (cnt_q == CNT_MAX) begin
            state_q <= S_HOLD;
            evt_q   <= 1'b1;
          end
        end
        S_HOLD: begin
          if (change) state_q <= S_SETTLE;
        end
        default: state_q <= S_IDLE;
      endcase
    end
  end

  // Returns {bad, code}; the dot bit is ignored except for the lone-dot pattern.
  function automatic logic [4:0] decode_seg(input logic [7:0] d);
    logic [4:0] r;
    r = {1'b1, 4'hF};
    if (d == 8'h7F) begin
      r = {1'b0, 4'hE};
    end else begin
      case ({1'b1, d[6:0]})
        8'hC0:   r = {1'b0, 4'h0};
        8'hF9:   r = {1'b0, 4'h1};
        8'hA4:   r = {1'b0, 4'h2};
        8'hB0:   r = {1'b0, 4'h3};
        8'h99:   r = {1'b0, 4'h4};
        8'h92:   r = {1'b0, 4'h5};
        8'h82:   r = {1'b0, 4'h6};
        8'hF8:   r = {1'b0, 4'h7};
        8'h80:   r = {1'b0, 4'h8};
        8'h90:   r = {1'b0, 4'h9};
        8'h88:   r = {1'b0, 4'hA};
        8'h83:   r = {1'b0, 4'hB};
        8'hC6:   r = {1'b0, 4'hC};
        8'hA1:   r = {1'b0, 4'hD};
        8'hFF:   r = {1'b0, 4'hF};
        default: r = {1'b1, 4'hF};
      endcase
    end
    return r;
  endfunction

  // prev_q still holds the settled value on the cycle after the settle event.
  logic [3:0] smp_com;
  logic [7:0] smp_data;
  logic [1:0] pos;
  logic       pos_vld;
  logic [4:0] dec;
  logic       capture, com_bad, frame_done;

  assign {smp_com, smp_data} = prev_q;
  assign dec                 = decode_seg(smp_data);

  always_comb begin
    pos     = 2'd0;
    pos_vld = 1'b1;
    case (smp_com)
      4'b1110: pos = 2'd0;
      4'b1101: pos = 2'd1;
      4'b1011: pos = 2'd2;
      4'b0111: pos = 2'd3;
      default: pos_vld = 1'b0;
    endcase
  end

  assign capture = evt_q && pos_vld;
  assign com_bad = evt_q && !pos_vld;

  logic [15:0]   slot_code_q, slot_code_d;
  logic [3:0]    slot_dot_q, slot_dot_d;
  logic [3:0]    slot_bad_q, slot_bad_d;
  logic [3:0]    flag_q, flag_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [15:0]   digits_q;
  logic [3:0]    dots_q, bad_seg_q;
  logic          fv_q, cerr_q, stall_q;

  assign frame_done = &flag_q;

  // A capture landing on the completion cycle survives the flag clear for the next frame.
  always_comb begin
    slot_code_d = slot_code_q;
    slot_dot_d  = slot_dot_q;
    slot_bad_d  = slot_bad_q;
    flag_d      = frame_done ? 4'b0000 : flag_q;
    if (capture) begin
      slot_code_d[{pos, 2'b00} +: 4] = dec[3:0];
      slot_dot_d[pos]                = ~smp_data[7];
      slot_bad_d[pos]                = dec[4];
      flag_d[pos]                    = 1'b1;
    end
  end

  always_comb begin
    tmo_d = tmo_q;
    if (capture) begin
      tmo_d = '0;
    end else if (tmo_q != TMO_MAX) begin
      tmo_d = tmo_q + TW'(1);
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      slot_code_q <= 16'hFFFF;
      slot_dot_q  <= '0;
      slot_bad_q  <= '0;
      flag_q      <= '0;
      tmo_q       <= '0;
      digits_q    <= 16'hFFFF;
      dots_q      <= '0;
      bad_seg_q   <= '0;
      fv_q        <= 1'b0;
      cerr_q      <= 1'b0;
      stall_q     <= 1'b0;
    end else begin
      slot_code_q <= slot_code_d;
      slot_dot_q  <= slot_dot_d;
      slot_bad_q  <= slot_bad_d;
      flag_q      <= flag_d;
      tmo_q       <= tmo_d;
      fv_q        <= frame_done;
      cerr_q      <= com_bad;
      stall_q     <= (tmo_d == TMO_MAX);
      if (frame_done) begin
        digits_q  <= slot_code_q;
        dots_q    <= slot_dot_q;
        bad_seg_q <= slot_bad_q;
      end
    end
  end

  assign bus.o_digits      = digits_q;
  assign bus.o_dots        = dots_q;
  assign bus.o_bad_seg     = bad_seg_q;
  assign bus.o_frame_valid = fv_q;
  assign bus.o_com_err     = cerr_q;
  assign bus.o_stall       = stall_q;

endmodule

// File: tb/tb_fnd_scan_decoder.sv
// Scoreboard bench: a digit-level model predicts frames and com errors; a monitor checks the DUT.
module tb_fnd_scan_decoder;
  localparam int S = 16;
  localparam int T = 1000;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  fnd_scan_decoder_if bus ();

  fnd_scan_decoder #(.SETTLE_CYCLES(S), .TIMEOUT_CYCLES(T)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  typedef struct {
    logic [15:0] dig;
    logic [3:0]  dot;
    logic [3:0]  bad;
  } frame_t;

  int     n_vec = 0;
  int     n_err = 0;
  frame_t exp_q[$];
  int     exp_cerr = 0;
  int     got_cerr = 0;

  logic [3:0]  m_code[4];
  logic        m_dot[4];
  logic        m_bad[4];
  logic        m_flag[4];
  logic [11:0] m_prev;
  bit          m_armed;
  logic [7:0]  pat_tab[16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [7:0] d);
    logic [7:0] m;
    if (d == 8'h7F) return {1'b0, 4'hE};
    m = d | 8'h80;
    for (int i = 0; i < 16; i++)
      if (i != 14 && pat_tab[i] == m) return {1'b0, 4'(i)};
    return {1'b1, 4'hF};
  endfunction

  function automatic int ref_pos(input logic [3:0] c);
    int z = 0;
    int p = -1;
    for (int i = 0; i < 4; i++)
      if (!c[i]) begin
        z++;
        p = i;
      end
    return (z == 1) ? p : -1;
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 4; i++) begin
      m_code[i] = 4'hF;
      m_dot[i]  = 1'b0;
      m_bad[i]  = 1'b0;
      m_flag[i] = 1'b0;
    end
    m_prev  = 12'hFFF;
    m_armed = 1'b1;
  endtask

  task automatic model_capture(input logic [11:0] v);
    int         p;
    logic [4:0] r;
    frame_t     f;
    p = ref_pos(v[11:8]);
    if (p < 0) begin
      exp_cerr++;
      return;
    end
    r         = ref_decode(v[7:0]);
    m_code[p] = r[3:0];
    m_bad[p]  = r[4];
    m_dot[p]  = ~v[7];
    m_flag[p] = 1'b1;
    if (m_flag[0] && m_flag[1] && m_flag[2] && m_flag[3]) begin
      f.dig = {m_code[3], m_code[2], m_code[1], m_code[0]};
      f.dot = {m_dot[3], m_dot[2], m_dot[1], m_dot[0]};
      f.bad = {m_bad[3], m_bad[2], m_bad[1], m_bad[0]};
      exp_q.push_back(f);
      for (int i = 0; i < 4; i++) m_flag[i] = 1'b0;
    end
  endtask

  // A held value is sampled only if settling was armed when it appeared; a value cut
  // short mid-settle leaves the decoder idle until the following change.
  task automatic seg(input logic [11:0] v, input int len);
    bus.fnd_com  = v[11:8];
    bus.fnd_data = v[7:0];
    if (m_armed) begin
      if (len > S) model_capture(v);
      m_armed = (len > S);
    end else begin
      m_armed = 1'b1;
    end
    m_prev = v;
    repeat (len) @(negedge clk);
  endtask

  task automatic chk_reset_vals(input string tag);
    chk({tag, "_digits"}, bus.o_digits, 16'hFFFF);
    chk({tag, "_dots"}, bus.o_dots, 0);
    chk({tag, "_bad"}, bus.o_bad_seg, 0);
    chk({tag, "_fv"}, bus.o_frame_valid, 0);
    chk({tag, "_cerr"}, bus.o_com_err, 0);
    chk({tag, "_stall"}, bus.o_stall, 0);
  endtask

  task automatic do_reset();
    chk("frames_pending_before_reset", exp_q.size(), 0);
    bus.fnd_com  = 4'hF;
    bus.fnd_data = 8'hFF;
    repeat (2) @(negedge clk);
    #2 reset = 1'b0;
    #1 chk_reset_vals("midreset");
    exp_q.delete();
    model_clear();
    repeat (4) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic rand_seg();
    logic [3:0]  c;
    logic [7:0]  d;
    logic [11:0] v;
    int          len;
    if ($urandom_range(0, 4) != 0) begin
      c = 4'hF;
      c[$urandom_range(0, 3)] = 1'b0;
    end else begin
      c = 4'($urandom);
    end
    if ($urandom_range(0, 2) != 0) begin
      d = pat_tab[$urandom_range(0, 15)];
      if ($urandom_range(0, 1) == 1) d = d & 8'h7F;
    end else begin
      d = 8'($urandom);
    end
    v = {c, d};
    if (v == m_prev) v[0] = ~v[0];
    len = ($urandom_range(0, 5) == 0) ? $urandom_range(1, S - 1) : $urandom_range(S + 2, S + 30);
    seg(v, len);
  endtask

  // Monitor: pops the scoreboard whenever the DUT publishes a frame.
  frame_t mf;
  logic   fv_prev = 1'b0;
  always @(negedge clk) begin
    if (!reset) begin
      fv_prev = 1'b0;
    end else begin
      if (bus.o_com_err) got_cerr++;
      if (bus.o_frame_valid) begin
        chk("fv_back_to_back", fv_prev, 0);
        if (exp_q.size() == 0) begin
          chk("frame_expected", 0, 1);
        end else begin
          mf = exp_q.pop_front();
          chk("frame_digits", bus.o_digits, mf.dig);
          chk("frame_dots", bus.o_dots, mf.dot);
          chk("frame_bad", bus.o_bad_seg, mf.bad);
        end
      end
      fv_prev = bus.o_frame_valid;
    end
  end

  initial begin
    pat_tab = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
                8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h7F, 8'hFF};
    model_clear();
    reset        = 1'b0;
    bus.fnd_com  = 4'hF;
    bus.fnd_data = 8'hFF;
    repeat (3) @(negedge clk);
    chk_reset_vals("reset");
    reset = 1'b1;
    @(negedge clk);

    // Normal scan 3210, twice.
    repeat (2) begin
      seg({4'b1110, 8'hC0}, S + 20);
      seg({4'b1101, 8'hF9}, S + 20);
      seg({4'b1011, 8'hA4}, S + 20);
      seg({4'b0111, 8'hB0}, S + 20);
    end

    // Dot and blank: expect FE04 with dots 0110.
    seg({4'b1110, 8'h99}, S + 12);
    seg({4'b1101, 8'h40}, S + 12);
    seg({4'b1011, 8'h7F}, S + 12);
    seg({4'b0111, 8'hFF}, S + 12);

    // Glitch rejection: 10-cycle glitch ignored, 20-cycle glitch captured.
    seg({4'b1110, 8'hF8}, S + 10);
    seg({4'b1101, 8'h90}, 10);
    seg({4'b1110, 8'hF8}, S + 10);
    seg({4'b1101, 8'h90}, 20);
    seg({4'b1110, 8'hF8}, S + 10);

    // Invalid com, then an unrecognised pattern completing a frame.
    seg({4'b1100, 8'hC0}, S + 10);
    seg({4'b1011, 8'h13}, S + 10);
    seg({4'b0111, 8'h88}, S + 10);
    seg({4'b1100, 8'hA1}, S + 10);
    seg({4'b1110, 8'hC6}, S + 10);
    seg({4'b1101, 8'h83}, S + 10);

    // Stall: freeze after a valid sample, then resume.
    seg({4'b1011, 8'h92}, S + T - 20);
    chk("stall_before_timeout", bus.o_stall, 0);
    repeat (50) @(negedge clk);
    chk("stall_after_timeout", bus.o_stall, 1);
    seg({4'b0111, 8'h82}, S + 10);
    chk("stall_cleared", bus.o_stall, 0);

    // Reset after two captures, then a frame needs four fresh ones.
    seg({4'b1110, 8'hF9}, S + 10);
    seg({4'b1101, 8'hA4}, S + 10);
    seg({4'b1011, 8'hB0}, S + 10);
    seg({4'b0111, 8'h99}, S + 10);
    seg({4'b1110, 8'h80}, S + 10);
    seg({4'b1101, 8'h88}, S + 10);
    repeat (10) @(negedge clk);
    do_reset();
    chk_reset_vals("after_release");
    seg({4'b1110, 8'hB0}, S + 10);
    seg({4'b1101, 8'hB0}, S + 10);
    seg({4'b1011, 8'hB0}, S + 10);
    seg({4'b1011, 8'hC0}, S + 10);
    chk("no_frame_after_3", bus.o_digits, 16'hFFFF);
    seg({4'b0111, 8'hB0}, S + 10);

    // Randomized scan.
    for (int k = 0; k < 400; k++) rand_seg();

    repeat (S + 20) @(negedge clk);
    chk("frames_outstanding", exp_q.size(), 0);
    chk("com_err_count", got_cerr, exp_cerr);
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
